// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache refill path.
package cache_pkg;

    localparam int unsigned ADDRESS_WORD_SIZE = 32;
    localparam int unsigned TAG_SIZE          = 19;
    localparam int unsigned INDEX_SIZE        = 7;
    localparam int unsigned OFFSET_SIZE       = 6;
    localparam int unsigned BLOCK_SIZE        = 8;
    localparam int unsigned MEM_DATA_WIDTH    = 64;

    localparam logic [2:0] LAST_BEAT = 3'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_SEND,
        RD_REQ,
        RD_WAIT,
        DONE
    } refill_state_e;

endpackage

// File: rtl/refill_addr_gen.sv
// Beat byte address for either the fill line or the dirty victim line.
module refill_addr_gen
    import cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WORD_SIZE = cache_pkg::ADDRESS_WORD_SIZE,
    parameter int unsigned TAG_SIZE          = cache_pkg::TAG_SIZE,
    parameter int unsigned INDEX_SIZE        = cache_pkg::INDEX_SIZE
) (
    input  logic                         use_victim,
    input  logic [TAG_SIZE-1:0]          tag,
    input  logic [TAG_SIZE-1:0]          victim_tag,
    input  logic [INDEX_SIZE-1:0]        index,
    input  logic [2:0]                   beat,
    output logic [ADDRESS_WORD_SIZE-1:0] addr
);

    logic [TAG_SIZE-1:0]          sel_tag;
    logic [ADDRESS_WORD_SIZE-1:0] base;

    always_comb begin
        sel_tag = use_victim ? victim_tag : tag;
        base    = ADDRESS_WORD_SIZE'({sel_tag, index, {OFFSET_SIZE{1'b0}}});
        addr    = base + ADDRESS_WORD_SIZE'({beat, 3'b000});
    end

endmodule

// File: rtl/cache_refill_engine.sv
// Miss handler: writes back a dirty victim line, then fetches and fills the
// missing line into the chosen way, one 64-bit beat per memory transaction.
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WORD_SIZE = cache_pkg::ADDRESS_WORD_SIZE,
    parameter int unsigned TAG_SIZE          = cache_pkg::TAG_SIZE,
    parameter int unsigned INDEX_SIZE        = cache_pkg::INDEX_SIZE,
    parameter int unsigned BLOCK_SIZE        = cache_pkg::BLOCK_SIZE,
    parameter int unsigned MEM_DATA_WIDTH    = cache_pkg::MEM_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDRESS_WORD_SIZE-1:0] req_addr,
    input  logic [1:0]                   req_way,
    input  logic                         req_dirty,
    input  logic [TAG_SIZE-1:0]          req_victim_tag,
    output logic                         arr_rd_en,
    output logic [2:0]                   arr_rd_beat,
    input  logic [MEM_DATA_WIDTH-1:0]    arr_rd_data,
    output logic                         arr_wr_en,
    output logic [1:0]                   arr_wr_way,
    output logic [2:0]                   arr_wr_beat,
    output logic [MEM_DATA_WIDTH-1:0]    arr_wr_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_we,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0]    mem_wdata,
    input  logic                         mem_rvalid,
    input  logic [MEM_DATA_WIDTH-1:0]    mem_rdata,
    output logic                         done
);

    localparam logic [2:0] LAST = 3'(BLOCK_SIZE - 1);

    refill_state_e               state_q, state_d;
    logic [2:0]                  beat_q, beat_d;
    logic [TAG_SIZE-1:0]         tag_q, tag_d;
    logic [TAG_SIZE-1:0]         vtag_q, vtag_d;
    logic [INDEX_SIZE-1:0]       index_q, index_d;
    logic [1:0]                  way_q, way_d;
    logic [MEM_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                        fresh_q, fresh_d;
    logic [MEM_DATA_WIDTH-1:0]   wdata_cur;
    logic                        use_victim;
    logic [ADDRESS_WORD_SIZE-1:0] beat_addr;
    logic                        unused_offset;

    assign unused_offset = ^req_addr[OFFSET_SIZE-1:0];
    assign use_victim    = (state_q == WB_SEND);

    refill_addr_gen #(
        .ADDRESS_WORD_SIZE(ADDRESS_WORD_SIZE),
        .TAG_SIZE         (TAG_SIZE),
        .INDEX_SIZE       (INDEX_SIZE)
    ) u_addr_gen (
        .use_victim(use_victim),
        .tag       (tag_q),
        .victim_tag(vtag_q),
        .index     (index_q),
        .beat      (beat_q),
        .addr      (beat_addr)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        tag_d         = tag_q;
        vtag_d        = vtag_q;
        index_d       = index_q;
        way_d         = way_q;
        wdata_d       = wdata_q;
        fresh_d       = 1'b0;
        wdata_cur     = '0;
        req_ready     = 1'b0;
        arr_rd_en     = 1'b0;
        arr_rd_beat   = '0;
        arr_wr_en     = 1'b0;
        arr_wr_way    = '0;
        arr_wr_beat   = '0;
        arr_wr_data   = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_d   = req_addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
                    index_d = req_addr[OFFSET_SIZE +: INDEX_SIZE];
                    way_d   = req_way;
                    vtag_d  = req_victim_tag;
                    beat_d  = '0;
                    state_d = req_dirty ? WB_RD : RD_REQ;
                end
            end
            WB_RD: begin
                arr_rd_en   = 1'b1;
                arr_rd_beat = beat_q;
                fresh_d     = 1'b1;
                state_d     = WB_SEND;
            end
            WB_SEND: begin
                // Array data is only valid in the first WB_SEND cycle; it is
                // forwarded then and held from the register while stalled.
                wdata_cur     = fresh_q ? arr_rd_data : wdata_q;
                wdata_d       = wdata_cur;
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = beat_addr;
                mem_wdata     = wdata_cur;
                if (mem_req_ready) begin
                    if (beat_q == LAST) begin
                        beat_d  = '0;
                        state_d = RD_REQ;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = WB_RD;
                    end
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = beat_addr;
                if (mem_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_way  = way_q;
                    arr_wr_beat = beat_q;
                    arr_wr_data = mem_rdata;
                    if (beat_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet for the whole reset cycle, not just after it.
        if (rst_b) begin
            req_ready     = 1'b0;
            arr_rd_en     = 1'b0;
            arr_rd_beat   = '0;
            arr_wr_en     = 1'b0;
            arr_wr_way    = '0;
            arr_wr_beat   = '0;
            arr_wr_data   = '0;
            mem_req_valid = 1'b0;
            mem_we        = 1'b0;
            mem_addr      = '0;
            mem_wdata     = '0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            way_q   <= '0;
            wdata_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            index_q <= index_d;
            way_q   <= way_d;
            wdata_q <= wdata_d;
            fresh_q <= fresh_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine with memory/array models and scoreboards.
module tb_cache_refill_engine;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_way;
    logic        req_dirty;
    logic [18:0] req_victim_tag;
    logic        arr_rd_en;
    logic [2:0]  arr_rd_beat;
    logic [63:0] arr_rd_data;
    logic        arr_wr_en;
    logic [1:0]  arr_wr_way;
    logic [2:0]  arr_wr_beat;
    logic [63:0] arr_wr_data;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        done;

    always #5 clk = ~clk;

    cache_refill_engine dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_way(req_way), .req_dirty(req_dirty), .req_victim_tag(req_victim_tag),
        .arr_rd_en(arr_rd_en), .arr_rd_beat(arr_rd_beat), .arr_rd_data(arr_rd_data),
        .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_beat(arr_wr_beat),
        .arr_wr_data(arr_wr_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .done(done)
    );

    typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; } mem_exp_t;
    typedef struct { logic [1:0] way; logic [2:0] beat; logic [63:0] data; } wr_exp_t;

    mem_exp_t mem_q[$];
    wr_exp_t  wr_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          resp_delay = 3;
    logic        resp_pending = 1'b0;
    int          resp_at = 0;
    logic [31:0] resp_addr = '0;
    logic        prev_rd_en = 1'b0;
    logic [2:0]  prev_rd_beat = '0;
    logic [18:0] cur_vtag = '0;
    logic        spurious = 1'b0;
    logic        stall_armed = 1'b0;
    logic [31:0] stall_addr = '0;
    int          stall_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [63:0] hold_wdata = '0;
    logic        hold_we = 1'b0;
    logic        done_expected = 1'b0;
    int          accept_cyc = 0;
    int          done_cyc = 0;
    int          exp_lat = 0;
    int          rd_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] vdata(input logic [18:0] vt, input logic [2:0] b);
        return 64'hA500_0000_0000_0000 | (64'(vt) << 8) | 64'(b);
    endfunction

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory/array models at the falling edge, then observe.
    task automatic step();
        mem_exp_t me;
        wr_exp_t  we_;
        @(negedge clk);
        arr_rd_data = prev_rd_en ? vdata(cur_vtag, prev_rd_beat) : {$urandom, $urandom};
        mem_rvalid  = 1'b0;
        mem_rdata   = {$urandom, $urandom};
        if (resp_pending && cyc == resp_at) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = mdata(resp_addr);
            resp_pending = 1'b0;
        end
        if (spurious) begin
            mem_rvalid = 1'b1;
            spurious   = 1'b0;
        end
        if (stall_armed && mem_req_valid && mem_addr == stall_addr) begin
            stall_cnt   = 5;
            stall_armed = 1'b0;
        end
        if (stall_cnt > 0) begin
            mem_req_ready = 1'b0;
            stall_cnt--;
        end else begin
            mem_req_ready = 1'b1;
        end
        #1;
        if (hold_prev) begin
            check("hold_valid", mem_req_valid, 1'b1);
            check("hold_we", mem_we, hold_we);
            check("hold_addr", mem_addr, hold_addr);
            check("hold_wdata", mem_wdata, hold_wdata);
            check("hold_no_rd", arr_rd_en, 1'b0);
        end
        hold_prev  = mem_req_valid && !mem_req_ready;
        hold_addr  = mem_addr;
        hold_wdata = mem_wdata;
        hold_we    = mem_we;
        if (mem_req_valid && mem_req_ready) begin
            if (mem_q.size() == 0) begin
                check("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
                me = mem_q.pop_front();
                check("mem_we", mem_we, me.we);
                check("mem_addr", mem_addr, me.addr);
                if (me.we) check("mem_wdata", mem_wdata, me.wdata);
            end
            if (!mem_we) begin
                resp_pending = 1'b1;
                resp_at      = cyc + resp_delay;
                resp_addr    = mem_addr;
                rd_hs++;
            end
        end
        if (arr_wr_en) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", arr_wr_en, 1'b0);
            end else begin
                we_ = wr_q.pop_front();
                check("wr_way", arr_wr_way, we_.way);
                check("wr_beat", arr_wr_beat, we_.beat);
                check("wr_data", arr_wr_data, we_.data);
            end
        end
        prev_rd_en   = arr_rd_en;
        prev_rd_beat = arr_rd_beat;
        if (done) begin
            if (!done_expected) begin
                check("done_extra", done, 1'b0);
            end else begin
                done_expected = 1'b0;
                done_cyc      = cyc;
                check("latency", 64'(cyc - accept_cyc), 64'(exp_lat));
            end
        end
    endtask

    task automatic push_expect(input logic [31:0] a, input logic [1:0] w, input logic d,
                               input logic [18:0] vt);
        logic [31:0] fill_base, wb_base;
        fill_base = {a[31:6], 6'b0};
        wb_base   = {vt, a[12:6], 6'b0};
        if (d) begin
            for (int i = 0; i < 8; i++)
                mem_q.push_back('{1'b1, wb_base + 32'(i * 8), vdata(vt, 3'(i))});
        end
        for (int i = 0; i < 8; i++) begin
            mem_q.push_back('{1'b0, fill_base + 32'(i * 8), 64'd0});
            wr_q.push_back('{w, 3'(i), mdata(fill_base + 32'(i * 8))});
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [1:0] w, input logic d,
                             input logic [18:0] vt);
        req_addr       = a;
        req_way        = w;
        req_dirty      = d;
        req_victim_tag = vt;
        req_valid      = 1'b1;
    endtask

    // Hold req_valid until the engine is ready; the following edge accepts.
    task automatic wait_accept(input logic d, input int extra);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            if (req_ready) begin
                accept_cyc = cyc;
                got        = 1'b1;
            end
            step();
        end
        req_valid = 1'b0;
        if (!got) check("accept_timeout", got, 1'b1);
        cur_vtag      = req_victim_tag;
        exp_lat       = (d ? 16 : 0) + 8 * (resp_delay + 1) + 1 + extra;
        done_expected = 1'b1;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400 && done_expected; n++) step();
        if (done_expected) begin
            check("done_timeout", done_expected, 1'b0);
            done_expected = 1'b0;
        end
        step();
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag, input logic exp_ready);
        check({tag, "_ctl"}, {arr_rd_en, arr_rd_beat, arr_wr_en, arr_wr_way, arr_wr_beat,
                              mem_req_valid, mem_we, done, req_ready},
              {14'd0, exp_ready});
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_data"}, arr_wr_data | mem_wdata, 64'd0);
    endtask

    initial begin
        rst_b = 1'b1; req_valid = 1'b0; req_addr = '0; req_way = '0; req_dirty = 1'b0;
        req_victim_tag = '0; arr_rd_data = '0; mem_req_ready = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = '0;

        step();
        step();
        check_quiet("reset", 1'b0);
        rst_b = 1'b0;
        step();
        check_quiet("idle", 1'b1);

        // Clean miss, 3-edge read response (two empty RD_WAIT cycles)
        resp_delay = 3;
        push_expect(32'h0000_2A40, 2'd2, 1'b0, 19'h0);
        drive_req(32'h0000_2A40, 2'd2, 1'b0, 19'h0);
        wait_accept(1'b0, 0);
        wait_done();

        // Dirty miss with all-ones victim tag
        resp_delay = 1;
        push_expect(32'h0000_0A40, 2'd1, 1'b1, 19'h7FFFF);
        drive_req(32'h0000_0A40, 2'd1, 1'b1, 19'h7FFFF);
        wait_accept(1'b1, 0);
        wait_done();

        // Writeback beat 3 stalled for five cycles
        resp_delay  = 2;
        stall_addr  = {19'h12345, 7'h1B, 6'b0} + 32'd24;
        stall_armed = 1'b1;
        push_expect(32'hABCD_06C7, 2'd3, 1'b1, 19'h12345);
        drive_req(32'hABCD_06C7, 2'd3, 1'b1, 19'h12345);
        wait_accept(1'b1, 5);
        wait_done();
        check("stall_used", stall_armed, 1'b0);

        // Second request held while busy; taken the cycle after done
        resp_delay = 1;
        push_expect(32'h1357_9BC0, 2'd0, 1'b0, 19'h0);
        drive_req(32'h1357_9BC0, 2'd0, 1'b0, 19'h0);
        wait_accept(1'b0, 0);
        step(); step(); step();
        push_expect(32'h2468_ACE0, 2'd3, 1'b0, 19'h0);
        drive_req(32'h2468_ACE0, 2'd3, 1'b0, 19'h0);
        for (int n = 0; n < 4; n++) begin
            step();
            check("busy_ready", req_ready, 1'b0);
        end
        wait_accept(1'b0, 0);
        check("accept_after_done", 64'(accept_cyc), 64'(done_cyc + 1));
        wait_done();

        // Reset while waiting for beat 5 data; the late response must be dropped
        resp_delay = 3;
        rd_hs      = 0;
        push_expect(32'h0055_5AC0, 2'd1, 1'b0, 19'h0);
        drive_req(32'h0055_5AC0, 2'd1, 1'b0, 19'h0);
        wait_accept(1'b0, 0);
        for (int n = 0; n < 300 && rd_hs < 6; n++) step();
        check("rst_reach_beat5", 64'(rd_hs), 64'd6);
        step();
        check("rst_pending_wr", 64'(wr_q.size()), 64'd3);
        rst_b = 1'b1;
        step();
        check_quiet("midrst", 1'b0);
        rst_b = 1'b0;
        mem_q.delete();
        wr_q.delete();
        done_expected = 1'b0;
        hold_prev     = 1'b0;
        step();
        check("late_rvalid_seen", mem_rvalid, 1'b1);
        check_quiet("late_rvalid", 1'b1);
        step();
        check_quiet("after_late", 1'b1);

        // Spurious read data while idle
        spurious = 1'b1;
        step();
        check("spurious_wr", arr_wr_en, 1'b0);
        step();
        check_quiet("spurious_idle", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
